// File: rtl/block_threshold_scheduler.sv
// Block-level pruning front-end: streams two rows of tile scores, tracks min/max/sum,
// divides for the mean and registers per-row pruning thresholds behind a valid/ack handshake.
module block_threshold_scheduler #(
    parameter int width = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [9:0]           noOfTiles,
    input  logic [2:0]           blockPruningRatio,
    input  logic                 score_valid,
    input  logic [2*width-1:0]   score0,
    input  logic [2*width-1:0]   score1,
    output logic                 score_ready,
    output logic                 busy,
    output logic [2*width-1:0]   threshold0,
    output logic [2*width-1:0]   threshold1,
    output logic                 thr_valid,
    input  logic                 thr_ack,
    output logic                 err
);
    localparam int SW = 2 * width;
    localparam int AW = SW + 10;
    localparam int IW = $clog2(AW);

    typedef enum logic [2:0] {IDLE, ACCUM, DIVIDE, FINAL, DONE} state_t;

    state_t                 state_q, state_d;
    logic [9:0]             n_q, n_d, cnt_q, cnt_d;
    logic [2:0]             ratio_q, ratio_d;
    logic [IW-1:0]          iter_q, iter_d;
    logic [1:0][SW-1:0]     min_q, min_d, max_q, max_d, thr_q, thr_d;
    logic [1:0][AW-1:0]     sum_q, sum_d;
    logic [1:0][9:0]        rem_q, rem_d;
    logic                   err_q, err_d;

    logic [1:0][SW-1:0]     score_in;
    logic [1:0][10:0]       shift_w;
    logic [1:0][9:0]        diff_w;
    logic [1:0]             ge_w;

    function automatic logic [SW-1:0] avg(input logic [SW-1:0] a, input logic [SW-1:0] b);
        logic [SW:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[SW:1];
    endfunction

    assign score_in = {score1, score0};

    // Restoring-division step; the sum registers double as the quotient shift registers.
    always_comb begin
        for (int r = 0; r < 2; r++) begin
            shift_w[r] = {rem_q[r], sum_q[r][AW-1]};
            ge_w[r]    = shift_w[r] >= {1'b0, n_q};
            diff_w[r]  = shift_w[r][9:0] - n_q;
        end
    end

    always_comb begin
        // NOTE: every _d defaults to its _q first, so no branch can infer a latch.
        state_d = state_q;
        n_d     = n_q;
        cnt_d   = cnt_q;
        ratio_d = ratio_q;
        iter_d  = iter_q;
        min_d   = min_q;
        max_d   = max_q;
        sum_d   = sum_q;
        rem_d   = rem_q;
        thr_d   = thr_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    n_d     = noOfTiles;
                    ratio_d = (blockPruningRatio > 3'd4) ? 3'd4 : blockPruningRatio;
                    cnt_d   = '0;
                    sum_d   = '0;
                    min_d   = '1;
                    max_d   = '0;
                    err_d   = 1'b0;
                    if (noOfTiles == 10'd0) begin
                        thr_d   = '0;
                        err_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        state_d = ACCUM;
                    end
                end
            end
            ACCUM: begin
                if (score_valid) begin
                    for (int r = 0; r < 2; r++) begin
                        if (score_in[r] < min_q[r]) min_d[r] = score_in[r];
                        if (score_in[r] > max_q[r]) max_d[r] = score_in[r];
                        sum_d[r] = sum_q[r] + AW'(score_in[r]);
                    end
                    cnt_d = cnt_q + 10'd1;
                    if (cnt_q + 10'd1 == n_q) begin
                        iter_d  = '0;
                        rem_d   = '0;
                        state_d = DIVIDE;
                    end
                end
            end
            DIVIDE: begin
                for (int r = 0; r < 2; r++) begin
                    rem_d[r] = ge_w[r] ? diff_w[r] : shift_w[r][9:0];
                    sum_d[r] = {sum_q[r][AW-2:0], ge_w[r]};
                end
                iter_d = iter_q + 1'b1;
                if (iter_q == IW'(AW - 1)) state_d = FINAL;
            end
            FINAL: begin
                for (int r = 0; r < 2; r++) begin
                    case (ratio_q)
                        3'd0:    thr_d[r] = min_q[r];
                        3'd1:    thr_d[r] = avg(min_q[r], sum_q[r][SW-1:0]);
                        3'd2:    thr_d[r] = sum_q[r][SW-1:0];
                        3'd3:    thr_d[r] = avg(max_q[r], sum_q[r][SW-1:0]);
                        default: thr_d[r] = max_q[r];
                    endcase
                end
                state_d = DONE;
            end
            DONE: begin
                if (thr_ack) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only; all registers here are
    // plain flops, so each one is cleared by the asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            n_q     <= '0;
            cnt_q   <= '0;
            ratio_q <= '0;
            iter_q  <= '0;
            min_q   <= '0;
            max_q   <= '0;
            sum_q   <= '0;
            rem_q   <= '0;
            thr_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            cnt_q   <= cnt_d;
            ratio_q <= ratio_d;
            iter_q  <= iter_d;
            min_q   <= min_d;
            max_q   <= max_d;
            sum_q   <= sum_d;
            rem_q   <= rem_d;
            thr_q   <= thr_d;
            err_q   <= err_d;
        end
    end

    assign score_ready = (state_q == ACCUM);
    assign busy        = (state_q != IDLE);
    assign thr_valid   = (state_q == DONE);
    assign threshold0  = thr_q[0];
    assign threshold1  = thr_q[1];
    assign err         = err_q;
endmodule

// File: tb/tb_block_threshold_scheduler.sv
// Scoreboard bench: the driver queues hand-computed thresholds per block, and a negedge
// monitor compares them (plus err and latency) whenever thr_valid rises.
module tb_block_threshold_scheduler;
    logic        clk = 1'b0;
    logic        rst, start, score_valid, thr_ack;
    logic [9:0]  noOfTiles;
    logic [2:0]  blockPruningRatio;
    logic [15:0] score0, score1, threshold0, threshold1;
    logic        score_ready, busy, thr_valid, err;

    always #5 clk = ~clk;

    block_threshold_scheduler #(.width(8)) dut (
        .clk(clk), .rst(rst), .start(start), .noOfTiles(noOfTiles),
        .blockPruningRatio(blockPruningRatio), .score_valid(score_valid),
        .score0(score0), .score1(score1), .score_ready(score_ready), .busy(busy),
        .threshold0(threshold0), .threshold1(threshold1), .thr_valid(thr_valid),
        .thr_ack(thr_ack), .err(err)
    );

    typedef struct {
        logic [15:0] t0;
        logic [15:0] t1;
        logic        e;
        int          lat;
        bit          from_start;
    } exp_t;

    exp_t sb_q[$];
    int   compared   = 0;
    int   mismatched = 0;
    int   cyc        = 0;
    int   acc_edge   = 0;
    int   start_edge = 0;
    logic prev_valid = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Monitor: records accept/start edges and scores each thr_valid rise.
    always @(negedge clk) begin : monitor
        exp_t x;
        if (score_valid && score_ready) acc_edge = cyc + 1;
        if (start && !busy) start_edge = cyc + 1;
        if (thr_valid && !prev_valid) begin
            if (sb_q.size() == 0) begin
                check("unexpected_thr_valid", 1, 0);
            end else begin
                x = sb_q.pop_front();
                check("threshold0", threshold0, x.t0);
                check("threshold1", threshold1, x.t1);
                check("err", err, x.e);
                check("latency", cyc - (x.from_start ? start_edge : acc_edge), x.lat);
            end
        end
        prev_valid = thr_valid;
    end

    function automatic logic [15:0] sc(input int mode, input int row, input int i);
        case (mode)
            0:       return (row == 0) ? 16'(10 * (i + 1)) : ((i == 3) ? 16'd100 : 16'd0);
            1:       return 16'hFFFF;
            default: return (row == 0) ? 16'hFFFF : 16'd0;
        endcase
    endfunction

    task automatic feed(input int n, input int mode, input bit gaps);
        int i;
        bit tog, v;
        i   = 0;
        tog = 1'b0;
        while (i < n) begin
            v   = !(gaps && tog);
            tog = !tog;
            score_valid = v;
            if (v) begin
                score0 = sc(mode, 0, i);
                score1 = sc(mode, 1, i);
            end
            @(posedge clk) #1;
            if (v) i++;
        end
        score_valid = 1'b0;
    endtask

    task automatic run_block(input int n, input int r, input int mode, input bit gaps,
                             input bit hold_ack, input logic [15:0] e0, input logic [15:0] e1,
                             input logic ee);
        exp_t x;
        int   k;
        x.t0 = e0; x.t1 = e1; x.e = ee;
        x.lat = (n == 0) ? 0 : 27;
        x.from_start = (n == 0);
        sb_q.push_back(x);
        @(posedge clk) #1;
        start = 1'b1; noOfTiles = n[9:0]; blockPruningRatio = r[2:0];
        @(posedge clk) #1;
        start = 1'b0;
        feed(n, mode, gaps);
        if (hold_ack) thr_ack = 1'b1;
        if (gaps && n > 0) begin
            repeat (2) @(posedge clk) #1;
            start = 1'b1; score_valid = 1'b1; score0 = 16'd0; score1 = 16'hFFFF;
            repeat (3) @(posedge clk) #1;
            start = 1'b0; score_valid = 1'b0;
        end
        k = 0;
        while (!thr_valid && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (!thr_valid) begin
            check("thr_valid_timeout", 0, 1);
            thr_ack = 1'b0;
        end else if (hold_ack) begin
            @(negedge clk);
            check("done_one_cycle", thr_valid, 0);
            thr_ack = 1'b0;
            check("idle_after_ack", busy, 0);
        end else begin
            if (gaps) begin
                @(posedge clk) #1;
                start = 1'b1; score_valid = 1'b1;
                @(posedge clk) #1;
                start = 1'b0; score_valid = 1'b0;
            end
            @(posedge clk) #1;
            thr_ack = 1'b1;
            @(posedge clk) #1;
            thr_ack = 1'b0;
            check("idle_after_ack", busy, 0);
            check("thr_held", threshold0, e0);
        end
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, got running, expected done");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; start = 1'b0; score_valid = 1'b0; thr_ack = 1'b0;
        noOfTiles = '0; blockPruningRatio = '0; score0 = '0; score1 = '0;
        #12;
        check("rst_busy", busy, 0);
        check("rst_thr_valid", thr_valid, 0);
        check("rst_score_ready", score_ready, 0);
        check("rst_err", err, 0);
        check("rst_threshold0", threshold0, 0);
        check("rst_threshold1", threshold1, 0);
        @(negedge clk) rst = 1'b0;

        // 4-tile block under every ratio code; ratio 4 also holds ack while entering DONE.
        run_block(4, 2, 0, 1'b0, 1'b0, 16'd25, 16'd25, 1'b0);
        run_block(4, 0, 0, 1'b0, 1'b0, 16'd10, 16'd0,  1'b0);
        run_block(4, 1, 0, 1'b0, 1'b0, 16'd17, 16'd12, 1'b0);
        run_block(4, 3, 0, 1'b0, 1'b0, 16'd32, 16'd62, 1'b0);
        run_block(4, 4, 0, 1'b0, 1'b1, 16'd40, 16'd100, 1'b0);
        run_block(4, 7, 0, 1'b0, 1'b0, 16'd40, 16'd100, 1'b0);

        // Maximum block.
        run_block(1023, 2, 1, 1'b0, 1'b0, 16'hFFFF, 16'hFFFF, 1'b0);
        run_block(1023, 2, 2, 1'b0, 1'b0, 16'hFFFF, 16'h0000, 1'b0);

        // Gaps and stray start/score_valid pulses.
        run_block(4, 2, 0, 1'b1, 1'b0, 16'd25, 16'd25, 1'b0);

        // Zero tiles, then a normal block clears err.
        run_block(0, 2, 0, 1'b0, 1'b0, 16'd0, 16'd0, 1'b1);
        run_block(4, 1, 0, 1'b0, 1'b0, 16'd17, 16'd12, 1'b0);

        // Reset in the middle of DIVIDE aborts with no output.
        @(posedge clk) #1;
        start = 1'b1; noOfTiles = 10'd4; blockPruningRatio = 3'd2;
        @(posedge clk) #1;
        start = 1'b0;
        feed(4, 0, 1'b0);
        repeat (10) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_thr_valid", thr_valid, 0);
        check("midrst_score_ready", score_ready, 0);
        check("midrst_err", err, 0);
        check("midrst_threshold0", threshold0, 0);
        check("midrst_threshold1", threshold1, 0);
        @(negedge clk) rst = 1'b0;
        run_block(4, 3, 0, 1'b0, 1'b0, 16'd32, 16'd62, 1'b0);

        repeat (5) @(posedge clk);
        check("scoreboard_empty", sb_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
